fetch_prefetch_queue: RTL

FETCH_PREFETCH_QUEUE -- requirements
Module: fetch_prefetch_queue

---
 rtl/fetch_prefetch_queue.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/fetch_prefetch_queue.sv
// Instruction fetch unit: one-outstanding-request fetch FSM feeding a small
// prefetch FIFO, drained into the IF/ID register one entry per unstalled cycle.
module fetch_prefetch_queue #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h00000060,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall_in,
  input  logic                         redirect_valid,
  input  logic [31:0]                  redirect_target,
  output logic                         inst_read,
  output logic [31:0]                  inst_addr,
  input  logic                         inst_resp,
  input  logic [31:0]                  inst_rdata,
  output logic [31:0]                  pc_ff,
  output logic [31:0]                  instr_ff,
  output logic                         valid_ff,
  output logic [$clog2(DEPTH+1)-1:0]   q_count
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH+1);
  localparam int CW1 = CW + 1;

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t        state, state_next;
  logic [31:0]   fetch_pc, fetch_pc_next;
  logic [31:0]   drain_addr;
  logic [31:0]   redir_pc;
  logic          push, pop, flush;
  logic [CW:0]   count_pushed;
  logic [PW-1:0] head, tail;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   data_mem [DEPTH];

  // Memory handshake: inst_read/inst_addr stay stable from issue until the
  // cycle inst_resp is high; that cycle completes the request.
  assign redir_pc     = redirect_target & ~32'd1;
  assign pop          = !redirect_valid && !stall_in && (q_count != '0);
  assign count_pushed = {1'b0, q_count} + CW1'(1) - CW1'(pop);
  assign inst_addr    = (state == DRAIN) ? drain_addr : fetch_pc;

  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    push          = 1'b0;
    flush         = 1'b0;
    inst_read     = 1'b0;
    case (state)
      IDLE: begin
        if (redirect_valid) begin
          fetch_pc_next = redir_pc;
          flush         = 1'b1;
          state_next    = REQ;
        end else if (q_count < CW'(DEPTH)) begin
          state_next = REQ;
        end
      end
      REQ: begin
        inst_read = 1'b1;
        if (inst_resp && redirect_valid) begin
          fetch_pc_next = redir_pc;
          flush         = 1'b1;
          state_next    = REQ;
        end else if (inst_resp) begin
          push          = 1'b1;
          fetch_pc_next = fetch_pc + 32'd4;
          state_next    = (count_pushed < CW1'(DEPTH)) ? REQ : IDLE;
        end else if (redirect_valid) begin
          fetch_pc_next = redir_pc;
          flush         = 1'b1;
          state_next    = DRAIN;
        end
      end
      DRAIN: begin
        // The stale response still has to be absorbed before a new issue.
        inst_read = 1'b1;
        if (redirect_valid) begin
          fetch_pc_next = redir_pc;
          flush         = 1'b1;
        end
        if (inst_resp) state_next = REQ;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      fetch_pc   <= RESET_PC;
      drain_addr <= RESET_PC;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      if (state == REQ && state_next == DRAIN) drain_addr <= fetch_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head    <= '0;
      tail    <= '0;
      q_count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      q_count <= q_count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail]   <= fetch_pc;
      data_mem[tail] <= inst_rdata;
    end
  end

  // A redirect squashes the IF/ID slot even while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_ff    <= 32'd0;
      instr_ff <= NOP_INSTR;
      valid_ff <= 1'b0;
    end else if (redirect_valid) begin
      instr_ff <= NOP_INSTR;
      valid_ff <= 1'b0;
    end else if (!stall_in) begin
      if (q_count != '0) begin
        pc_ff    <= pc_mem[head];
        instr_ff <= data_mem[head];
        valid_ff <= 1'b1;
      end else begin
        instr_ff <= NOP_INSTR;
        valid_ff <= 1'b0;
      end
    end
  end

endmodule
